// File: rtl/soc_bus_pkg.sv
// Shared constants and encodings for the 65xx SoC bus fabric: page defaults,
// wait-FSM states, slot-index width and read-mux select codes.
package soc_bus_pkg;

    localparam logic [3:0] RAMPAGE_DEF = 4'h0;
    localparam logic [3:0] IOPAGE_DEF  = 4'hd;

    localparam int SLOT_IDX_W = 6;
    localparam int WAIT_CNT_W = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        SEL_ROM  = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_SLOT = 2'd2
    } sel_e;

endpackage

// File: rtl/soc_pclk_gen.sv
// Modulo-DIV peripheral clock-enable generator: one-cycle strobe every DIV
// clocks, first strobe DIV cycles after reset release.
module soc_pclk_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_pclk
);

    localparam int              CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_pclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= '0;
            r_pclk <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_pclk <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_pclk <= 1'b0;
        end
    end

    assign o_pclk = r_pclk;

endmodule

// File: rtl/soc_bus_fabric.sv
// Address decode, registered read-data mux, slot wait-state insertion and IRQ
// merge for the 65xx SoC. Wait states are built only when SLOT_WAIT_EN is defined.
module soc_bus_fabric
    import soc_bus_pkg::*;
#(
    parameter int               CLK_FREQ  = 35000000,
    parameter int               PCLK_FREQ = 3500000,
    parameter int               NSLOT     = 4,
    parameter logic [3:0]       RAMPAGE   = RAMPAGE_DEF,
    parameter logic [3:0]       IOPAGE    = IOPAGE_DEF,
    parameter logic [3*NSLOT-1:0] SLOT_WAIT = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [15:0]        cpu_ab,
    input  logic               cpu_we_n,
    output logic [7:0]         cpu_di,
    output logic               cpu_rdy,
    output logic               bus_we_n,
    output logic               ram_we,
    input  logic [7:0]         ram_do,
    input  logic [7:0]         rom_do,
    output logic [NSLOT-1:0]   slot_cs_n,
    input  logic [8*NSLOT-1:0] slot_do,
    input  logic [NSLOT-1:0]   slot_irq_n,
    input  logic               ext_irq_n,
    output logic               cpu_irq_n,
    output logic               pclk
);

    localparam int PCLK_DIV = CLK_FREQ / PCLK_FREQ;

    logic [3:0]            w_page;
    logic [SLOT_IDX_W-1:0] w_idx;
    logic                  w_ram_hit;
    logic                  w_io_page;
    logic [NSLOT-1:0]      w_slot_hit_vec;
    logic                  w_slot_hit;
    sel_e                  w_sel;
    sel_e                  r_sel;
    logic [SLOT_IDX_W-1:0] r_idx;
    logic [7:0]            w_slot_data;
    logic                  r_irq_s1;
    logic                  r_irq_s2;
    logic                  w_unused_ab;

    assign w_page      = cpu_ab[15:12];
    assign w_idx       = cpu_ab[11:6];
    assign w_ram_hit   = (w_page == RAMPAGE);
    assign w_io_page   = (w_page == IOPAGE);
    assign w_unused_ab = ^cpu_ab[5:0];

    // Subpages at or above NSLOT match no slot and therefore fall through to ROM.
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
        assign w_slot_hit_vec[gi] = w_io_page && (w_idx == SLOT_IDX_W'(gi));
        assign slot_cs_n[gi]      = ~w_slot_hit_vec[gi];
    end

    assign w_slot_hit = |w_slot_hit_vec;

    always_comb begin
        w_sel = SEL_ROM;
        if (w_ram_hit)
            w_sel = SEL_RAM;
        else if (w_slot_hit)
            w_sel = SEL_SLOT;
    end

    // Decode is registered so the mux lines up with the synchronous memories.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel <= SEL_ROM;
            r_idx <= '0;
        end else begin
            r_sel <= w_sel;
            r_idx <= w_idx;
        end
    end

    always_comb begin
        w_slot_data = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (r_idx == SLOT_IDX_W'(i))
                w_slot_data = slot_do[8*i +: 8];
        end
        case (r_sel)
            SEL_RAM:  cpu_di = ram_do;
            SEL_SLOT: cpu_di = w_slot_data;
            default:  cpu_di = rom_do;
        endcase
    end

`ifdef SLOT_WAIT_EN
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic [WAIT_CNT_W-1:0] w_cnt_next;
    logic [WAIT_CNT_W-1:0] w_wait;
    logic                  w_stall;

    always_comb begin
        w_wait = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (w_slot_hit_vec[i])
                w_wait = SLOT_WAIT[3*i +: 3];
        end
    end

    // The first stall cycle is raised combinationally in IDLE, so WAIT covers
    // the remaining W-1 cycles and RELEASE guarantees one ready cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_slot_hit && (w_wait != '0)) begin
                    w_stall      = 1'b1;
                    w_cnt_next   = w_wait - 1'b1;
                    w_state_next = (w_wait == WAIT_CNT_W'(1)) ? ST_RELEASE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_stall    = 1'b1;
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt == WAIT_CNT_W'(1))
                    w_state_next = ST_RELEASE;
            end
            ST_RELEASE: w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Reset forces ready immediately even while a slow slot is still addressed.
    assign cpu_rdy  = ~w_stall | ~reset_n;
    assign bus_we_n = cpu_we_n | ~cpu_rdy;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = ^SLOT_WAIT;
    assign cpu_rdy      = 1'b1;
    assign bus_we_n     = cpu_we_n;
`endif

    assign ram_we = ~bus_we_n & w_ram_hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_s1 <= 1'b1;
            r_irq_s2 <= 1'b1;
        end else begin
            r_irq_s1 <= ext_irq_n;
            r_irq_s2 <= r_irq_s1;
        end
    end

    assign cpu_irq_n = r_irq_s2 & (&slot_irq_n);

    soc_pclk_gen #(
        .DIV (PCLK_DIV)
    ) u_pclk_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .o_pclk  (pclk)
    );

endmodule
